// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad matrix scanner.
package keypad_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam int FRAME_W  = NUM_COLS * NUM_ROWS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } kp_state_e;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_SINGLE,
    CLS_MULTI
  } frame_cls_e;

  typedef struct packed {
    frame_cls_e  cls;
    logic [3:0]  idx;   // bit index {col,row}, meaningful only for CLS_SINGLE
  } frame_class_t;

  // Popcount-style classification of a full scan frame.
  function automatic frame_class_t classify_frame(input logic [FRAME_W-1:0] f);
    frame_class_t r;
    logic [4:0]   cnt;
    cnt   = '0;
    r.idx = '0;
    for (int i = 0; i < FRAME_W; i++) begin
      if (f[i]) begin
        cnt   = cnt + 5'd1;
        r.idx = 4'(i);
      end
    end
    if (cnt == 5'd0)      r.cls = CLS_NONE;
    else if (cnt == 5'd1) r.cls = CLS_SINGLE;
    else                  r.cls = CLS_MULTI;
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer; resets to all-ones so idle (pulled-up) rows read as released.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Metastability chain, runs every clk regardless of scan tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad matrix scanner: column strobe, frame capture, debounce FSM.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       CE,
  input  logic [3:0] row_in,
  output logic [3:0] column,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [3:0] DS = 4'(DEBOUNCE_SCANS);

  logic [3:0]         row_sync;
  logic [3:0]         row_s;
  logic [1:0]         col_idx_q, col_idx_d;
  logic [3:0]         column_q, column_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [FRAME_W-1:0] frame_full;
  kp_state_e          state_q, state_d;
  logic [3:0]         cand_q, cand_d;
  logic [3:0]         dcnt_q, dcnt_d;
  logic [3:0]         dcnt_inc;
  logic [3:0]         key_code_q, key_code_d;
  logic               key_valid_q, key_valid_d;
  logic               key_held_q, key_held_d;
  logic               frame_done;
  logic               cand_hit;
  frame_class_t       fcls;

  sync_2ff #(.WIDTH(4)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row_in),
    .q   (row_sync)
  );

  assign row_s = ~row_sync;

  // Current frame with the column being sampled this tick merged in.
  always_comb begin
    frame_full = frame_q;
    frame_full[{col_idx_q, 2'b00} +: 4] = row_s;
  end

  assign frame_done = CE && (col_idx_q == 2'd3);
  assign cand_hit   = frame_full[cand_q];
  assign dcnt_inc   = (dcnt_q == 4'hF) ? 4'hF : dcnt_q + 4'd1;

  // Classify the completed frame.
  always_comb begin
    fcls = classify_frame(frame_full);
  end

  // Next-state logic: scan advance on CE, debounce FSM on frame completion.
  always_comb begin
    col_idx_d   = col_idx_q;
    column_d    = column_q;
    frame_d     = frame_q;
    state_d     = state_q;
    cand_d      = cand_q;
    dcnt_d      = dcnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    if (CE) begin
      col_idx_d = col_idx_q + 2'd1;
      column_d  = ~(4'b0001 << col_idx_d);
      frame_d   = frame_full;
    end

    if (frame_done) begin
      unique case (state_q)
        ST_IDLE: begin
          if (fcls.cls == CLS_SINGLE) begin
            cand_d = fcls.idx;
            dcnt_d = 4'd1;
            if (DS == 4'd1) begin
              state_d     = ST_PRESSED;
              key_code_d  = fcls.idx;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (fcls.cls == CLS_SINGLE && fcls.idx == cand_q) begin
            dcnt_d = dcnt_inc;
            if (dcnt_inc >= DS) begin
              state_d     = ST_PRESSED;
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
            dcnt_d  = 4'd0;
          end
        end
        ST_PRESSED: begin
          // Other keys are ignored while the candidate stays down (no rollover).
          if (!cand_hit) begin
            if (DS == 4'd1) begin
              state_d    = ST_IDLE;
              dcnt_d     = 4'd0;
              key_held_d = 1'b0;
            end else begin
              state_d = ST_RELEASE;
              dcnt_d  = 4'd1;
            end
          end
        end
        ST_RELEASE: begin
          if (!cand_hit) begin
            dcnt_d = dcnt_inc;
            if (dcnt_inc >= DS) begin
              state_d    = ST_IDLE;
              dcnt_d     = 4'd0;
              key_held_d = 1'b0;
            end
          end else begin
            // Release bounce: back to held without a new valid pulse.
            state_d = ST_PRESSED;
            dcnt_d  = 4'd0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_idx_q   <= 2'd0;
      column_q    <= 4'b1110;
      frame_q     <= '0;
      state_q     <= ST_IDLE;
      cand_q      <= 4'd0;
      dcnt_q      <= 4'd0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      col_idx_q   <= col_idx_d;
      column_q    <= column_d;
      frame_q     <= frame_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      dcnt_q      <= dcnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign column    = column_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
